// File: rtl/gpio_port_arbiter_pkg.sv
// Shared encodings for the GPIO port arbiter: FSM states, client op codes and port register map.
package gpio_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RDW  = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_DIR     = 2'd1;
    localparam logic [1:0] REG_IRQ     = 2'd2;
    localparam logic [1:0] REG_CAPTURE = 2'd3;

    localparam logic [3:0] AVM_BE_ALL = 4'hF;

endpackage

// File: rtl/gpio_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from i_ptr+1, wrapping.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);

    logic [PW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_cand = PW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/gpio_port_arbiter.sv
// Sole Avalon-MM master of the parallel port; serialises client READ/WRITE/RMW with atomic RMW.
// States: IDLE arbitrate | RD read strobe | RDW capture readdata | WR write strobe | ACK ack pulse
module gpio_port_arbiter
    import gpio_port_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [2*NREQ-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]   req_mask,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_read,
    output logic                 avm_write,
    output logic [3:0]           avm_byteenable,
    output logic [DW-1:0]        avm_writedata,
    input  logic [DW-1:0]        avm_readdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr, w_gnt_idx;
    logic [NREQ-1:0] w_grant, r_win_oh;
    logic [1:0]      r_op, r_addr, w_sel_op, w_sel_addr;
    logic [DW-1:0]   r_mask, r_wdata, r_rdata, w_sel_mask, w_sel_wdata, w_merge;

    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic            r_busy, r_cs, r_rd, r_wr;
    logic            w_busy_nxt, w_cs_nxt, w_rd_nxt, w_wr_nxt;
    logic [1:0]      r_address, w_address_nxt;
    logic [DW-1:0]   r_writedata, w_writedata_nxt;

    rr_arbiter #(.N(NREQ)) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx)
    );

    always_comb begin
        w_sel_op    = '0;
        w_sel_addr  = '0;
        w_sel_mask  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op    = req_op[i*2 +: 2];
                w_sel_addr  = req_addr[i*2 +: 2];
                w_sel_mask  = req_mask[i*DW +: DW];
                w_sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Merge uses the live readdata in RDW so the write can issue on the very next cycle.
    assign w_merge = (avm_readdata & ~r_mask) | (r_wdata & r_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|req) w_state_nxt = (w_sel_op == OP_WRITE) ? ST_WR : ST_RD;
            ST_RD:   w_state_nxt = ST_RDW;
            ST_RDW:  w_state_nxt = (r_op == OP_RMW) ? ST_WR : ST_ACK;
            ST_WR:   w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_nxt        = (w_state_nxt == ST_RD);
        w_wr_nxt        = (w_state_nxt == ST_WR);
        w_cs_nxt        = w_rd_nxt || w_wr_nxt;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_ack_nxt       = (w_state_nxt == ST_ACK) ? r_win_oh : '0;
        w_address_nxt   = r_address;
        w_writedata_nxt = r_writedata;
        if (w_cs_nxt) w_address_nxt = (r_state == ST_IDLE) ? w_sel_addr : r_addr;
        if (w_wr_nxt) w_writedata_nxt = (r_state == ST_IDLE) ? w_sel_wdata : w_merge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_cs        <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
        end else begin
            r_ack       <= w_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_cs        <= w_cs_nxt;
            r_rd        <= w_rd_nxt;
            r_wr        <= w_wr_nxt;
            r_address   <= w_address_nxt;
            r_writedata <= w_writedata_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr    <= PW'(NREQ - 1);
            r_win_oh <= '0;
            r_op     <= OP_READ;
            r_addr   <= '0;
            r_mask   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (r_state == ST_IDLE && |req) begin
                r_ptr    <= w_gnt_idx;
                r_win_oh <= w_grant;
                r_op     <= w_sel_op;
                r_addr   <= w_sel_addr;
                r_mask   <= w_sel_mask;
                r_wdata  <= w_sel_wdata;
            end
            if (r_state == ST_RDW) r_rdata <= avm_readdata;
        end
    end

    assign ack            = r_ack;
    assign rdata          = r_rdata;
    assign busy           = r_busy;
    assign avm_address    = r_address;
    assign avm_chipselect = r_cs;
    assign avm_read       = r_rd;
    assign avm_write      = r_wr;
    assign avm_byteenable = AVM_BE_ALL;
    assign avm_writedata  = r_writedata;

endmodule

// File: tb/tb_gpio_port_arbiter.sv
// Directed bench for gpio_port_arbiter with a 4-register port slave model (1-cycle read latency).
module tb_gpio_port_arbiter;
    import gpio_port_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_op, req_addr;
    logic [NREQ*DW-1:0]  req_mask, req_wdata;
    logic [NREQ-1:0]     ack;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic [1:0]          avm_address;
    logic                avm_chipselect, avm_read, avm_write;
    logic [3:0]          avm_byteenable;
    logic [DW-1:0]       avm_writedata;
    logic [DW-1:0]       avm_readdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_port_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_mask       (req_mask),
        .req_wdata      (req_wdata),
        .ack            (ack),
        .rdata          (rdata),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    // Port slave model; a write to CAPTURE clears it regardless of data.
    logic [DW-1:0] port_regs [4] = '{default: '0};
    logic          pre_en = 1'b0;
    logic [1:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            wr_cnt  = 0;
    int            ack_cnt = 0;

    always @(posedge clk) begin
        if (avm_chipselect && avm_write) begin
            wr_cnt <= wr_cnt + 1;
            if (avm_address == REG_CAPTURE) port_regs[3] <= '0;
            else                            port_regs[avm_address] <= avm_writedata;
        end
        if (avm_chipselect && avm_read) avm_readdata <= port_regs[avm_address];
        if (pre_en) port_regs[pre_addr] <= pre_data;
        if (|ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [1:0] a,
                           input logic [31:0] m, input logic [31:0] wd);
        req_op[r*2 +: 2]     = op;
        req_addr[r*2 +: 2]   = a;
        req_mask[r*DW +: DW] = m;
        req_wdata[r*DW +: DW] = wd;
        req[r]               = 1'b1;
    endtask

    task automatic do_op(input int r, input logic [1:0] op, input logic [1:0] a,
                         input logic [31:0] m, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
        set_req(r, op, a, m, wd);
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ack[r]) begin
                lat = c;
                rd  = rdata;
                break;
            end
        end
        req[r] = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_cs"}, avm_chipselect, 0);
        check({tag, "_rd"}, avm_read, 0);
        check({tag, "_wr"}, avm_write, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] got_ack [4];
        logic [31:0] got_rd  [4];
        int          n_got;
        int          wr_before, ack_before;

        reset_n   = 1'b0;
        req       = '0;
        req_op    = '0;
        req_addr  = '0;
        req_mask  = '0;
        req_wdata = '0;

        // Reset state and idle after release
        repeat (2) tick();
        check_all_zero("rst");
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_be", avm_byteenable, 32'hF);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_busy", busy, 0);
        end

        // WRITE DIR: strobe at grant+1, ack at grant+2
        set_req(0, OP_WRITE, REG_DIR, 32'h0, 32'h0000_00FF);
        tick();
        check("wr_strobe", avm_write, 1);
        check("wr_cs", avm_chipselect, 1);
        check("wr_addr", avm_address, REG_DIR);
        check("wr_data", avm_writedata, 32'h0000_00FF);
        check("wr_busy", busy, 1);
        check("wr_noack", ack, 0);
        tick();
        check("wr_ack", ack, 2'b01);
        check("wr_strobe_off", avm_write, 0);
        check("wr_dir", port_regs[1], 32'h0000_00FF);
        req[0] = 1'b0;
        tick();
        check("wr_ack_off", ack, 0);
        check("wr_idle", busy, 0);

        // RMW on DATA from requester 1: ack at grant+4
        preload(REG_DATA, 32'hA5A5_0000);
        set_req(1, OP_RMW, REG_DATA, 32'h0000_00FF, 32'h1234_5612);
        tick();
        check("rmw_rd", avm_read, 1);
        check("rmw_rd_cs", avm_chipselect, 1);
        check("rmw_rd_addr", avm_address, REG_DATA);
        check("rmw_rd_nowr", avm_write, 0);
        tick();
        check("rmw_rdw_rd", avm_read, 0);
        check("rmw_rdw_cs", avm_chipselect, 0);
        tick();
        check("rmw_wr", avm_write, 1);
        check("rmw_wdata", avm_writedata, 32'hA5A5_0012);
        check("rmw_noack", ack, 0);
        tick();
        check("rmw_ack", ack, 2'b10);
        check("rmw_rdata", rdata, 32'hA5A5_0000);
        check("rmw_data_reg", port_regs[0], 32'hA5A5_0012);
        req[1] = 1'b0;
        tick();

        // CAPTURE read, clear by write, read again; reserved op reads
        preload(REG_CAPTURE, 32'h0000_0004);
        do_op(0, OP_READ, REG_CAPTURE, 32'h0, 32'h0, lat, rd);
        check("cap_rd_lat", lat, 3);
        check("cap_rd", rd, 32'h0000_0004);
        do_op(0, OP_WRITE, REG_CAPTURE, 32'h0, 32'hFFFF_FFFF, lat, rd);
        check("cap_wr_lat", lat, 2);
        do_op(0, OP_READ, REG_CAPTURE, 32'h0, 32'h0, lat, rd);
        check("cap_clr_lat", lat, 3);
        check("cap_clr", rd, 32'h0);
        do_op(1, 2'd3, REG_DIR, 32'hFFFF_FFFF, 32'h0, lat, rd);
        check("rsv_lat", lat, 3);
        check("rsv_rd", rd, 32'h0000_00FF);
        check("rsv_nowrite", port_regs[1], 32'h0000_00FF);

        // Reset during RDW of an RMW: op lost, no write, no ack
        preload(REG_DATA, 32'h1111_2222);
        set_req(0, OP_RMW, REG_DATA, 32'h0000_FFFF, 32'h0);
        tick();
        tick();
        wr_before  = wr_cnt;
        ack_before = ack_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        req[0] = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("mid_rst_wrcnt", wr_cnt, wr_before);
        check("mid_rst_ackcnt", ack_cnt, ack_before);
        check("mid_rst_data", port_regs[0], 32'h1111_2222);
        check("mid_rst_idle", busy, 0);

        // Both requesters held from reset: grants must alternate starting with 0
        reset_n = 1'b0;
        set_req(0, OP_READ, REG_DATA, 32'h0, 32'h0);
        set_req(1, OP_READ, REG_DATA, 32'h0, 32'h0);
        tick();
        reset_n = 1'b1;
        n_got = 0;
        for (int i = 0; i < 4; i++) begin
            got_ack[i] = '0;
            got_rd[i]  = '0;
        end
        for (int c = 0; c < 60 && n_got < 4; c++) begin
            tick();
            if (|ack) begin
                got_ack[n_got] = 32'(ack);
                got_rd[n_got]  = rdata;
                n_got++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check("rr_ack", got_ack[i], (i % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_rdata", got_rd[i], 32'h1111_2222);
        end
        req = '0;
        repeat (2) tick();
        check("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
